regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the Harvard MIPS datapath. It replaces the fixed 2-read/1-write file with these additions:
- N read ports and two write ports: A for ALU writeback, B for long-latency load and multiply/divide results.
- A per-register pending-write scoreboard that drives the hazard stall.
- An optional same-cycle write-to-read bypass.

It sits between the decode stage (reads and issue) and the writeback stage (writes).

## Interface
Parameters:
- WIDTH, 32, data width in bits
- NREGS, 32, number of registers; power of two, at least 2
- NRD, 2, number of read ports
- DBG_IDX, 2, register index mirrored on dbg_q ($v0)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- ra  in  NRD×AW  read addresses, AW = $clog2(NREGS)
- rd  out  NRD×WIDTH  read data
- rd_busy  out  NRD  the addressed register has a pending port-B write
- we_a, wa_a, wd_a  in  1 / AW / WIDTH  port A write enable, address, data
- we_b, wa_b, wd_b  in  1 / AW / WIDTH  port B write enable, address, data
- iss_v, iss_a  in  1 / AW  issue of a long-latency op targeting iss_a
- stall  out  1  OR of rd_busy
- pend_cnt  out  $clog2(NREGS+1)  number of busy registers
- sb_err  out  1  sticky scoreboard protocol error
- dbg_q  out  WIDTH  rf[DBG_IDX]

## Operation
Reset:
- reset low clears every register, every busy bit, pend_cnt and sb_err asynchronously.
- While reset is low, every rd reads 0, dbg_q is 0 and stall is 0.

Register 0:
- Always reads 0 and is never busy.
- Writes and issues to register 0 are ignored and do not set sb_err.

Writes:
- Both write ports update on the posedge when their enable is high.
- If we_a and we_b target the same address in the same cycle, port A's data is stored and port B still clears the busy bit.

Scoreboard:
- iss_v sets busy[iss_a] on the next edge.
- A port-B write clears busy[wa_b].
- An issue and a port-B write to the same address in the same cycle leave the bit set; the issue wins.
- An issue to an already-busy register, or a port-B write to a non-busy register, sets sb_err. sb_err stays set until reset.

pend_cnt:
- Tracks the population of the busy bits.
- Changes by -1, 0 or +1 per cycle. It never wraps, because the maximum is NREGS-1.

Read flags:
- rd_busy[i] = busy[ra[i]], except that it reads 0 when port B writes ra[i] in that cycle and REGFILE_BYPASS_EN is defined.
- stall = |rd_busy.

## Timing
- Reads are combinational, with zero latency from ra to rd.
- Writes are visible on rd in the cycle after the write edge.
- Busy set and clear are visible one cycle after the edge that registers them.
- Reset assertion takes effect immediately. Deassertion is synchronised by the surrounding system and takes effect at the next posedge.
- Asserting reset mid-operation discards every pending issue. Port-B writes arriving after reset raise sb_err.

## Configuration
REGFILE_BYPASS_EN:
- Defined: a read of an address being written this cycle returns the write data, with port A taking priority over port B. The matching rd_busy is masked for a port-B hit.
- Undefined: reads return the stored value. rd_busy reflects the busy bit until the clearing edge, which adds one stall cycle.

## Structure
- Package regfile_pkg holds:
  - the AW and count-width localparams as functions of NREGS
  - typedef reg_addr_t
  - typedef sb_state_t for the busy vector
- Sub-module regfile_scoreboard holds the busy bits, pend_cnt and sb_err. The data array and read muxing stay in regfile_mp.

## Test plan
- Reset: reset low with prior contents → rd = 0, pend_cnt = 0, sb_err = 0, dbg_q = 0.
- Register 0: we_a to register 0 with 0xDEADBEEF, then read register 0 → rd = 0; iss_a = 0 → pend_cnt stays 0.
- Write conflict: we_a (r5, 0x11) and we_b (r5, 0x22) in the same cycle → r5 reads 0x11 next cycle.
- Scoreboard stall: issue r8, then read r8 → stall = 1 and pend_cnt = 1. A port-B write to r8 with 0x1234 then gives:
  - with bypass: stall = 0 in that cycle and rd = 0x1234
  - without bypass: stall = 0 one cycle later.
- Simultaneous set and clear: issue r9 and port-B write r9 in the same cycle, with r9 already busy → r9 stays busy, pend_cnt unchanged, sb_err = 0.
- Protocol error: port-B write to non-busy r4 → sb_err = 1 and stays 1 until reset.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared sizing helpers and types for the multi-port register file.
package regfile_pkg;

    function automatic int rf_aw(input int nregs);
        return $clog2(nregs);
    endfunction

    function automatic int rf_cw(input int nregs);
        return $clog2(nregs + 1);
    endfunction

    localparam int RF_NREGS = 32;
    localparam int RF_AW    = rf_aw(RF_NREGS);
    localparam int RF_CW    = rf_cw(RF_NREGS);

    typedef logic [RF_AW-1:0]    reg_addr_t;
    typedef logic [RF_NREGS-1:0] sb_state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: per-register busy bits set by long-latency issue,
// cleared by port-B writeback, with population count and sticky protocol error.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      iss_v,
    input  logic [rf_aw(NREGS)-1:0]   iss_a,
    input  logic                      we_b,
    input  logic [rf_aw(NREGS)-1:0]   wa_b,
    output logic [NREGS-1:0]          busy,
    output logic [rf_cw(NREGS)-1:0]   pend_cnt,
    output logic                      sb_err
);
    localparam int CW = rf_cw(NREGS);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [CW-1:0]    pend_cnt_q, pend_cnt_d;
    logic             sb_err_q, sb_err_d;
    logic             iss_hit, clr_hit, same, set_new, clr_real;

    always_comb begin
        iss_hit  = iss_v && (iss_a != '0);
        clr_hit  = we_b && (wa_b != '0);
        same     = iss_hit && clr_hit && (iss_a == wa_b);

        busy_d = busy_q;
        if (clr_hit) busy_d[wa_b]  = 1'b0;
        if (iss_hit) busy_d[iss_a] = 1'b1;

        // Count only real bit transitions; a same-address issue+clear of a busy bit is a no-op.
        set_new  = iss_hit && !busy_q[iss_a];
        clr_real = clr_hit && busy_q[wa_b] && !same;
        pend_cnt_d = pend_cnt_q;
        if (set_new && !clr_real)
            pend_cnt_d = pend_cnt_q + CW'(1);
        else if (clr_real && !set_new)
            pend_cnt_d = pend_cnt_q - CW'(1);

        sb_err_d = sb_err_q
                 | (iss_hit && busy_q[iss_a] && !same)
                 | (clr_hit && !busy_q[wa_b]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q     <= '0;
            pend_cnt_q <= '0;
            sb_err_q   <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            pend_cnt_q <= pend_cnt_d;
            sb_err_q   <= sb_err_d;
        end
    end

    assign busy     = busy_q;
    assign pend_cnt = pend_cnt_q;
    assign sb_err   = sb_err_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, write ports A/B, hazard scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NREGS   = 32,
    parameter int NRD     = 2,
    parameter int DBG_IDX = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NRD*rf_aw(NREGS)-1:0] ra,
    output logic [NRD*WIDTH-1:0]        rd,
    output logic [NRD-1:0]              rd_busy,
    input  logic                        we_a,
    input  logic [rf_aw(NREGS)-1:0]     wa_a,
    input  logic [WIDTH-1:0]            wd_a,
    input  logic                        we_b,
    input  logic [rf_aw(NREGS)-1:0]     wa_b,
    input  logic [WIDTH-1:0]            wd_b,
    input  logic                        iss_v,
    input  logic [rf_aw(NREGS)-1:0]     iss_a,
    output logic                        stall,
    output logic [rf_cw(NREGS)-1:0]     pend_cnt,
    output logic                        sb_err,
    output logic [WIDTH-1:0]            dbg_q
);
    localparam int AW = rf_aw(NREGS);

    logic [WIDTH-1:0] rf_q [NREGS];
    logic [WIDTH-1:0] rf_d [NREGS];
    logic [NREGS-1:0] busy;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_val;
    logic             rd_bsy;

    regfile_scoreboard #(
        .NREGS (NREGS)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .iss_v    (iss_v),
        .iss_a    (iss_a),
        .we_b     (we_b),
        .wa_b     (wa_b),
        .busy     (busy),
        .pend_cnt (pend_cnt),
        .sb_err   (sb_err)
    );

    // Port A is applied last so it wins an address collision with port B.
    always_comb begin
        rf_d = rf_q;
        if (we_b && (wa_b != '0)) rf_d[wa_b] = wd_b;
        if (we_a && (wa_a != '0)) rf_d[wa_a] = wd_a;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rf_q <= '{default: '0};
        else        rf_q <= rf_d;
    end

    always_comb begin
        rd      = '0;
        rd_busy = '0;
        rd_addr = '0;
        rd_val  = '0;
        rd_bsy  = 1'b0;
        for (int unsigned i = 0; i < NRD; i++) begin
            rd_addr = ra[i*AW +: AW];
            rd_val  = rf_q[rd_addr];
            rd_bsy  = busy[rd_addr];
`ifdef REGFILE_BYPASS_EN
            if (we_b && (wa_b == rd_addr) && (rd_addr != '0)) begin
                rd_val = wd_b;
                rd_bsy = 1'b0;
            end
            if (we_a && (wa_a == rd_addr) && (rd_addr != '0))
                rd_val = wd_a;
`endif
            rd[i*WIDTH +: WIDTH] = reset ? rd_val : '0;
            rd_busy[i]           = reset & rd_bsy;
        end
    end

    assign stall = |rd_busy;
    assign dbg_q = rf_q[DBG_IDX];

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: directed stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int W   = 32;
    localparam int N   = 32;
    localparam int NRD = 2;
    localparam int AW  = RF_AW;
    localparam int CW  = RF_CW;

    localparam int S_RD0  = 0;
    localparam int S_RD1  = 1;
    localparam int S_BUSY = 2;
    localparam int S_STL  = 3;
    localparam int S_PEND = 4;
    localparam int S_ERR  = 5;
    localparam int S_DBG  = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic [NRD*AW-1:0] ra;
    logic [NRD*W-1:0]  rd;
    logic [NRD-1:0]    rd_busy;
    logic              we_a, we_b, iss_v;
    reg_addr_t         wa_a, wa_b, iss_a, ra0, ra1;
    logic [W-1:0]      wd_a, wd_b;
    logic              stall, sb_err;
    logic [CW-1:0]     pend_cnt;
    logic [W-1:0]      dbg_q;

    always #5 clk = ~clk;
    assign ra = {ra1, ra0};

    regfile_mp #(
        .WIDTH   (W),
        .NREGS   (N),
        .NRD     (NRD),
        .DBG_IDX (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ra       (ra),
        .rd       (rd),
        .rd_busy  (rd_busy),
        .we_a     (we_a),
        .wa_a     (wa_a),
        .wd_a     (wd_a),
        .we_b     (we_b),
        .wa_b     (wa_b),
        .wd_b     (wd_b),
        .iss_v    (iss_v),
        .iss_a    (iss_a),
        .stall    (stall),
        .pend_cnt (pend_cnt),
        .sb_err   (sb_err),
        .dbg_q    (dbg_q)
    );

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic expect_v(input string name, input int sel, input logic [31:0] e);
        exp_t x;
        x.name = name;
        x.sel  = sel;
        x.exp  = e;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.sel)
                S_RD0:   act = rd[W-1:0];
                S_RD1:   act = rd[2*W-1:W];
                S_BUSY:  act = 32'(rd_busy);
                S_STL:   act = 32'(stall);
                S_PEND:  act = 32'(pend_cnt);
                S_ERR:   act = 32'(sb_err);
                default: act = dbg_q;
            endcase
            n_tests++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        we_a  = 1'b0;
        we_b  = 1'b0;
        iss_v = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        we_a = 1'b0; wa_a = '0; wd_a = '0;
        we_b = 1'b0; wa_b = '0; wd_b = '0;
        iss_v = 1'b0; iss_a = '0;
        ra0 = '0; ra1 = '0;
        tick();
        expect_v("init_pend", S_PEND, 0);
        expect_v("init_err",  S_ERR,  0);
        tick();
        reset = 1'b1;

        // prior contents, then asynchronous reset
        we_a = 1'b1; wa_a = 5'd2; wd_a = 32'hCAFE_F00D;
        iss_v = 1'b1; iss_a = 5'd3;
        ra0 = 5'd2; ra1 = 5'd3;
        tick();
        expect_v("pre_rd0",  S_RD0,  32'hCAFE_F00D);
        expect_v("pre_dbg",  S_DBG,  32'hCAFE_F00D);
        expect_v("pre_pend", S_PEND, 1);
        expect_v("pre_busy", S_BUSY, 32'h2);
        tick();
        reset = 1'b0;
        expect_v("rst_rd0",  S_RD0,  0);
        expect_v("rst_dbg",  S_DBG,  0);
        expect_v("rst_pend", S_PEND, 0);
        expect_v("rst_err",  S_ERR,  0);
        expect_v("rst_stl",  S_STL,  0);
        tick();
        reset = 1'b1;

        // register 0
        we_a = 1'b1; wa_a = 5'd0; wd_a = 32'hDEAD_BEEF;
        iss_v = 1'b1; iss_a = 5'd0;
        ra0 = 5'd0; ra1 = 5'd0;
        tick();
        expect_v("r0_rd",   S_RD0,  0);
        expect_v("r0_pend", S_PEND, 0);
        expect_v("r0_err",  S_ERR,  0);

        // write conflict on r5 (issued first so the port-B write is legal)
        iss_v = 1'b1; iss_a = 5'd5;
        tick();
        expect_v("r5_pend", S_PEND, 1);
        we_a = 1'b1; wa_a = 5'd5; wd_a = 32'h11;
        we_b = 1'b1; wa_b = 5'd5; wd_b = 32'h22;
        ra0 = 5'd5;
`ifdef REGFILE_BYPASS_EN
        expect_v("conf_byp", S_RD0, 32'h11);
`else
        expect_v("conf_old", S_RD0, 0);
`endif
        tick();
        expect_v("conf_rd",   S_RD0,  32'h11);
        expect_v("conf_pend", S_PEND, 0);
        expect_v("conf_err",  S_ERR,  0);

        // scoreboard stall on r8
        iss_v = 1'b1; iss_a = 5'd8;
        tick();
        ra0 = 5'd8;
        expect_v("r8_stall", S_STL,  1);
        expect_v("r8_busy",  S_BUSY, 32'h1);
        expect_v("r8_pend",  S_PEND, 1);
        we_b = 1'b1; wa_b = 5'd8; wd_b = 32'h1234;
`ifdef REGFILE_BYPASS_EN
        expect_v("r8_wb_stall", S_STL, 0);
        expect_v("r8_wb_rd",    S_RD0, 32'h1234);
`else
        expect_v("r8_wb_stall", S_STL, 1);
        expect_v("r8_wb_rd",    S_RD0, 0);
`endif
        tick();
        expect_v("r8_after_stall", S_STL,  0);
        expect_v("r8_after_rd",    S_RD0,  32'h1234);
        expect_v("r8_after_pend",  S_PEND, 0);

        // simultaneous set and clear on busy r9
        iss_v = 1'b1; iss_a = 5'd9;
        tick();
        ra0 = 5'd9;
        expect_v("r9_pend", S_PEND, 1);
        iss_v = 1'b1; iss_a = 5'd9;
        we_b = 1'b1; wa_b = 5'd9; wd_b = 32'h55;
`ifdef REGFILE_BYPASS_EN
        expect_v("r9_same_stall", S_STL, 0);
`else
        expect_v("r9_same_stall", S_STL, 1);
`endif
        tick();
        expect_v("r9_stall", S_STL,  1);
        expect_v("r9_pend2", S_PEND, 1);
        expect_v("r9_err",   S_ERR,  0);
        expect_v("r9_rd",    S_RD0,  32'h55);

        // protocol error: port-B write to idle r4
        we_b = 1'b1; wa_b = 5'd4; wd_b = 32'h77;
        ra1 = 5'd4;
        tick();
        expect_v("perr_err",  S_ERR,  1);
        expect_v("perr_pend", S_PEND, 1);
        expect_v("perr_rd1",  S_RD1,  32'h77);
        tick();
        expect_v("perr_sticky", S_ERR, 1);
        tick();
        reset = 1'b0;
        expect_v("perr_rst_err",  S_ERR,  0);
        expect_v("perr_rst_pend", S_PEND, 0);
        tick();
        reset = 1'b1;

        // pending issue was discarded: late port-B write is an error
        we_b = 1'b1; wa_b = 5'd9; wd_b = 32'h99;
        tick();
        expect_v("late_wb_err", S_ERR, 1);
        expect_v("late_pend",   S_PEND, 0);

        tick();
        tick();
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
